// File: rtl/bytewise_init_ram_if.sv
// bytewise_init_ram_if: write/read/init bus of bytewise_init_ram.
// Parity signals exist only when BYTEWISE_INIT_RAM_PARITY_EN is defined.
interface bytewise_init_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    logic                  init_req;
    logic                  init_busy;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [NB-1:0]         byte_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
    logic                  parity_inject;
    logic [NB-1:0]         parity_err;
    modport master (
        output init_req, write_enable, write_addr, byte_en, data_in, read_enable, read_addr, parity_inject,
        input  init_busy, data_out, data_valid, parity_err
    );
    modport slave (
        input  init_req, write_enable, write_addr, byte_en, data_in, read_enable, read_addr, parity_inject,
        output init_busy, data_out, data_valid, parity_err
    );
`else
    modport master (
        output init_req, write_enable, write_addr, byte_en, data_in, read_enable, read_addr,
        input  init_busy, data_out, data_valid
    );
    modport slave (
        input  init_req, write_enable, write_addr, byte_en, data_in, read_enable, read_addr,
        output init_busy, data_out, data_valid
    );
`endif
endinterface

// File: rtl/bytewise_init_ram.sv
// bytewise_init_ram: single-clock byte-enable RAM with registered read and an init sequencer.
// Optional per-lane even parity when BYTEWISE_INIT_RAM_PARITY_EN is defined.
module bytewise_init_ram #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    DEPTH       = 1024,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
    parameter bit                    READ_BYPASS = 1'b1
) (
    input logic                clk,
    input logic                rst,
    bytewise_init_ram_if.slave bus
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt, w_init_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out, w_rd_word;
    logic                  r_data_valid;
    logic                  w_ready, w_wr, w_rd, w_rd_in, w_same;

    assign w_ready = r_state == READY;
    assign w_wr    = !rst && w_ready && bus.write_enable && ({1'b0, bus.write_addr} <= LAST);
    assign w_rd    = w_ready && bus.read_enable;
    assign w_rd_in = {1'b0, bus.read_addr} <= LAST;
    assign w_same  = w_wr && bus.write_addr == bus.read_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        if (!w_ready) begin
            w_init_cnt_nxt = r_init_cnt + 1'b1;
            w_state_nxt    = {1'b0, r_init_cnt} == LAST ? READY : INIT;
        end else if (bus.init_req) begin
            w_state_nxt    = INIT;
            w_init_cnt_nxt = '0;
        end
    end

    // Forwarded lanes of a same-address write replace the old word when bypass is on.
    always_comb begin
        w_rd_word = w_rd_in ? r_mem[bus.read_addr] : '0;
        for (int i = 0; i < NB; i++)
            if (READ_BYPASS && w_same && bus.byte_en[i])
                w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

`ifdef BYTEWISE_INIT_RAM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_init_par, w_wr_par, w_rd_err, r_parity_err;

    always_comb begin
        w_init_par = '0;
        w_wr_par   = '0;
        w_rd_err   = '0;
        for (int i = 0; i < NB; i++) begin
            w_init_par[i] = ^INIT_VALUE[i*BYTE_WIDTH +: BYTE_WIDTH];
            w_wr_par[i]   = ^bus.data_in[i*BYTE_WIDTH +: BYTE_WIDTH] ^ bus.parity_inject;
            w_rd_err[i]   = w_rd_in && !(READ_BYPASS && w_same && bus.byte_en[i]) &&
                            (r_par[bus.read_addr][i] != ^r_mem[bus.read_addr][i*BYTE_WIDTH +: BYTE_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !w_ready)
            r_par[r_init_cnt] <= w_init_par;
        for (int i = 0; i < NB; i++)
            if (w_wr && bus.byte_en[i])
                r_par[bus.write_addr][i] <= w_wr_par[i];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_parity_err <= '0;
        else
            r_parity_err <= w_rd ? w_rd_err : '0;
    end

    assign bus.parity_err = r_parity_err;
`endif

    always_ff @(posedge clk) begin
        if (!rst && !w_ready)
            r_mem[r_init_cnt] <= INIT_VALUE;
        for (int i = 0; i < NB; i++)
            if (w_wr && bus.byte_en[i])
                r_mem[bus.write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd;
            r_data_out   <= w_rd ? w_rd_word : '0;
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.init_busy  = !w_ready;
endmodule

// File: tb/tb_bytewise_init_ram.sv
// tb_bytewise_init_ram: two RAMs (depth 12 with bypass, depth 16 without) on shared stimulus,
// compared every cycle against a word-level model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_bytewise_init_ram;
    localparam logic [31:0] IV = 32'h5A5A5A5A;

    logic        clk = 1'b0, rst = 1'b1;
    logic        init_req = 1'b0, we = 1'b0, re = 1'b0;
    logic [3:0]  wa = '0, ra = '0, be = '0;
    logic [31:0] din = '0;
    int          nchk = 0, nerr = 0;
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
    logic        pinj = 1'b0;
`endif

    always #5 clk = ~clk;

    bytewise_init_ram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) ifa ();
    bytewise_init_ram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) ifb ();

    assign ifa.init_req = init_req;  assign ifb.init_req = init_req;
    assign ifa.write_enable = we;    assign ifb.write_enable = we;
    assign ifa.write_addr = wa;      assign ifb.write_addr = wa;
    assign ifa.byte_en = be;         assign ifb.byte_en = be;
    assign ifa.data_in = din;        assign ifb.data_in = din;
    assign ifa.read_enable = re;     assign ifb.read_enable = re;
    assign ifa.read_addr = ra;       assign ifb.read_addr = ra;
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
    assign ifa.parity_inject = pinj; assign ifb.parity_inject = pinj;
`endif

    bytewise_init_ram #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12),
                        .INIT_VALUE(IV), .READ_BYPASS(1'b1)) ua (.clk(clk), .rst(rst), .bus(ifa.slave));
    bytewise_init_ram #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16),
                        .INIT_VALUE(IV), .READ_BYPASS(1'b0)) ub (.clk(clk), .rst(rst), .bus(ifb.slave));

    logic        d_busy [2], d_valid [2];
    logic [31:0] d_dout [2];
    assign d_busy[0] = ifa.init_busy;  assign d_busy[1] = ifb.init_busy;
    assign d_valid[0] = ifa.data_valid; assign d_valid[1] = ifb.data_valid;
    assign d_dout[0] = ifa.data_out;   assign d_dout[1] = ifb.data_out;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    function automatic int dep(input int k);
        return k == 0 ? 12 : 16;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        return (o & ~lanes(b)) | (n & lanes(b));
    endfunction

    // Word-level model: m_left counts remaining init cycles; instance 0 forwards same-address writes.
    logic [31:0] m_mem [2][16];
    int          m_left [2];
    logic [31:0] e_dout [2];
    logic        e_valid [2];
    logic        m_started = 1'b0;
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
    logic [3:0]  m_inj [2][16];
    logic [3:0]  e_perr [2];
    logic [3:0]  d_perr [2];
    assign d_perr[0] = ifa.parity_err; assign d_perr[1] = ifb.parity_err;
`endif

    always @(posedge clk) begin
        if (rst) m_started <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_left[k] <= dep(k);
                e_valid[k] <= 1'b0;
                e_dout[k] <= '0;
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
                e_perr[k] <= '0;
`endif
            end else if (m_left[k] > 0) begin
                m_mem[k][dep(k) - m_left[k]] <= IV;
                m_left[k] <= m_left[k] - 1;
                e_valid[k] <= 1'b0;
                e_dout[k] <= '0;
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
                m_inj[k][dep(k) - m_left[k]] <= '0;
                e_perr[k] <= '0;
`endif
            end else begin
                e_valid[k] <= re;
                e_dout[k] <= '0;
                if (re && int'(ra) < dep(k))
                    e_dout[k] <= (k == 0 && we && wa == ra) ? merge(m_mem[k][ra], din, be) : m_mem[k][ra];
                if (we && int'(wa) < dep(k))
                    m_mem[k][wa] <= merge(m_mem[k][wa], din, be);
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
                e_perr[k] <= '0;
                if (re && int'(ra) < dep(k))
                    e_perr[k] <= (k == 0 && we && wa == ra) ? (m_inj[k][ra] & ~be) : m_inj[k][ra];
                if (we && int'(wa) < dep(k))
                    m_inj[k][wa] <= (m_inj[k][wa] & ~be) | (pinj ? be : 4'h0);
`endif
                if (init_req) m_left[k] <= dep(k);
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy%0d", k), 32'(d_busy[k]), 32'(m_left[k] != 0));
                chk($sformatf("valid%0d", k), 32'(d_valid[k]), 32'(e_valid[k]));
                chk($sformatf("dout%0d", k), d_dout[k], e_dout[k]);
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
                chk($sformatf("perr%0d", k), 32'(d_perr[k]), 32'(e_perr[k]));
`endif
            end
        end
    end

    task automatic rd(input logic [3:0] a);
        re = 1'b1;
        ra = a;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1;
        wa = a;
        din = d;
        be = b;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Counts busy cycles from the current one; a user write to addr 2 is attempted mid-init.
    task automatic count_busy(output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifa.init_busy) ca++;
            if (ifb.init_busy) cb++;
            we = 1'(i == 2);
            wa = 4'd2;
            din = 32'hFFFF_FFFF;
            be = 4'hF;
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    task automatic check_all_init();
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            chk("init_rd_a", ifa.data_out, a < 12 ? IV : 32'h0);
            chk("init_vld_a", 32'(ifa.data_valid), 32'd1);
            chk("init_rd_b", ifb.data_out, IV);
        end
    endtask

    initial begin
        int ca, cb;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_busy(ca, cb);
        chk("init_len_a", ca, 12);
        chk("init_len_b", cb, 16);
        check_all_init();

        wr(4'd3, 32'hAABBCCDD, 4'hF);
        wr(4'd3, 32'h11223344, 4'b0010);
        rd(4'd3);
        chk("byte_en_a", ifa.data_out, 32'hAABB33DD);
        chk("byte_en_b", ifb.data_out, 32'hAABB33DD);

        wr(4'd5, 32'h0, 4'hF);
        we = 1'b1; wa = 4'd5; din = 32'hDEADBEEF; be = 4'hF;
        re = 1'b1; ra = 4'd5;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        chk("rdw_bypass", ifa.data_out, 32'hDEADBEEF);
        chk("rdw_old", ifb.data_out, 32'h0);
        rd(4'd5);
        chk("rdw_after_a", ifa.data_out, 32'hDEADBEEF);
        chk("rdw_after_b", ifb.data_out, 32'hDEADBEEF);

        wr(4'd13, 32'h12345678, 4'hF);
        rd(4'd13);
        chk("oor_rd_a", ifa.data_out, 32'h0);
        chk("oor_vld_a", 32'(ifa.data_valid), 32'd1);
        chk("inrange_b", ifb.data_out, 32'h12345678);
        rd(4'd1);
        chk("no_alias_a", ifa.data_out, IV);

`ifdef BYTEWISE_INIT_RAM_PARITY_EN
        pinj = 1'b1;
        wr(4'd1, 32'h01020304, 4'b0101);
        pinj = 1'b0;
        rd(4'd1);
        chk("perr_inj_a", 32'(ifa.parity_err), 32'h5);
        chk("perr_inj_b", 32'(ifb.parity_err), 32'h5);
        rd(4'd0);
        chk("perr_clean_a", 32'(ifa.parity_err), 32'h0);
`endif

        for (int n = 0; n < 600; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom);
            be = 4'($urandom);
            din = $urandom;
            re = 1'($urandom_range(0, 1));
            ra = $urandom_range(0, 3) == 0 ? wa : 4'($urandom);
            init_req = 1'($urandom_range(0, 40) == 0);
            rst = 1'($urandom_range(0, 150) == 0);
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
            pinj = 1'($urandom_range(0, 3) == 0);
`endif
            @(negedge clk);
        end
        we = 1'b0; re = 1'b0; init_req = 1'b0; rst = 1'b0;
`ifdef BYTEWISE_INIT_RAM_PARITY_EN
        pinj = 1'b0;
`endif
        for (int i = 0; i < 40 && (ifa.init_busy || ifb.init_busy); i++) @(negedge clk);
        chk("ready_after_rand", 32'(ifa.init_busy || ifb.init_busy), 32'd0);

        for (int a = 0; a < 16; a++) wr(4'(a), 32'(a), 4'hF);
        rd(4'd9);
        chk("fill_b", ifb.data_out, 32'd9);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        count_busy(ca, cb);
        chk("reinit_len_a", ca, 12);
        chk("reinit_len_b", cb, 16);
        check_all_init();

        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(ca, cb);
        chk("rst_mid_len_a", ca, 12);
        chk("rst_mid_len_b", cb, 16);
        check_all_init();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
